// File: rtl/axis_decimator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_decimator_pkg                                        |
// | Brief    : Shared constants, width helpers and factor clamp for the  |
// |            AXI-Stream decimator.                                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package axis_decimator_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  // Channel index width; a single channel still needs one bit
  function automatic int calc_ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Width able to hold the factor value MAX_FACTOR itself
  function automatic int calc_fw(input int max_f);
    return $clog2(max_f + 1);
  endfunction

  // Accumulator width: MAX_FACTOR full-scale samples never overflow
  function automatic int calc_acc_w(input int data_w, input int max_f);
    return data_w + $clog2(max_f);
  endfunction

  // Shift amount width able to express a full-width shift
  function automatic int calc_sh_w(input int acc_w);
    return $clog2(acc_w + 1);
  endfunction

  // Effective factor: 0 behaves as 1, oversize values saturate
  function automatic int clamp_factor(input int f, input int max_f);
    if (f < 1) begin
      return 1;
    end
    if (f > max_f) begin
      return max_f;
    end
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_decimator_acc_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_decimator_acc_bank                                   |
// | Brief    : Per-channel accumulator array with load / add / clear and |
// |            a combinational running-sum output for the selected chan. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module axis_decimator_acc_bank
  import axis_decimator_pkg::*;
#(
  parameter int N_CHANNELS = 1,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 12,
  parameter int CH_W       = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load_i,
  input  logic              add_i,
  input  logic              clear_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic [ACC_W-1:0] acc_q [N_CHANNELS];
  logic [ACC_W-1:0] sel_acc;

  // Select the accumulator of the addressed channel without out-of-range indexing
  always_comb begin
    sel_acc = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (ch_i == CH_W'(i)) begin
        sel_acc = acc_q[i];
      end
    end
  end

  assign sum_o = sel_acc + ACC_W'(data_i);

  // Clear wins over load/add; only the addressed channel is updated
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (ch_i == CH_W'(i)) begin
          if (load_i) begin
            acc_q[i] <= ACC_W'(data_i);
          end else if (add_i) begin
            acc_q[i] <= sum_o;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_decimator                                            |
// | Brief    : Runtime-configurable pick / boxcar-average decimator for  |
// |            time-interleaved multi-channel AXI-Stream samples.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module axis_decimator
  import axis_decimator_pkg::*;
#(
  parameter int TDATA_WIDTH    = 8,
  parameter int N_CHANNELS     = 1,
  parameter int MAX_FACTOR     = 16,
  parameter int DEFAULT_FACTOR = 4
) (
  input  logic                                                       aclk,
  input  logic                                                       aresetn,
  input  logic                                                       cfg_update,
  input  logic [calc_fw(MAX_FACTOR)-1:0]                             cfg_factor,
  input  logic                                                       cfg_mode,
  input  logic [calc_sh_w(calc_acc_w(TDATA_WIDTH, MAX_FACTOR))-1:0]  cfg_shift,
  input  logic                                                       s_axis_tvalid,
  output logic                                                       s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]                                     s_axis_tdata,
  output logic                                                       m_axis_tvalid,
  input  logic                                                       m_axis_tready,
  output logic [TDATA_WIDTH-1:0]                                     m_axis_tdata,
  output logic [calc_ch_w(N_CHANNELS)-1:0]                           m_axis_tuser
);

  localparam int CH_W  = calc_ch_w(N_CHANNELS);
  localparam int FW    = calc_fw(MAX_FACTOR);
  localparam int ACC_W = calc_acc_w(TDATA_WIDTH, MAX_FACTOR);
  localparam int SH_W  = calc_sh_w(ACC_W);

  logic [FW-1:0]          factor_q;
  logic                   mode_q;
  logic [SH_W-1:0]        shift_q;
  logic [CH_W-1:0]        ch_cnt_q, ch_cnt_d;
  logic [FW-1:0]          phase_q, phase_d;
  logic                   m_valid_q, m_valid_d;
  logic [TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]        m_user_q, m_user_d;

  logic                   beat_acc;
  logic                   ch_last;
  logic                   phase_first;
  logic                   phase_last;
  logic                   produce;
  logic [ACC_W-1:0]       acc_sum;
  logic [ACC_W-1:0]       avg_sum;
  logic [TDATA_WIDTH-1:0] out_data;

  // Ready only depends on the output register, never on s_axis_tvalid
  assign s_axis_tready = !m_valid_q || m_axis_tready;

  // A beat coinciding with a config update is consumed but has no effect
  assign beat_acc    = s_axis_tvalid && s_axis_tready && !cfg_update;
  assign ch_last     = (ch_cnt_q == CH_W'(N_CHANNELS - 1));
  assign phase_first = (phase_q == '0);
  assign phase_last  = (phase_q == factor_q - FW'(1));
  assign produce     = beat_acc && ((mode_q == MODE_PICK) ? phase_first : phase_last);

  axis_decimator_acc_bank #(
    .N_CHANNELS (N_CHANNELS),
    .DATA_W     (TDATA_WIDTH),
    .ACC_W      (ACC_W),
    .CH_W       (CH_W)
  ) u_acc_bank (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load_i  (beat_acc && (mode_q == MODE_AVG) && phase_first),
    .add_i   (beat_acc && (mode_q == MODE_AVG) && !phase_first),
    .clear_i (cfg_update),
    .ch_i    (ch_cnt_q),
    .data_i  (s_axis_tdata),
    .sum_o   (acc_sum)
  );

  // On the first phase the stored value is stale, so the sample stands alone
  assign avg_sum  = phase_first ? ACC_W'(s_axis_tdata) : acc_sum;
  assign out_data = (mode_q == MODE_AVG) ? TDATA_WIDTH'(avg_sum >> shift_q) : s_axis_tdata;

  // Channel / phase counters: channel advances per beat, phase per full frame
  always_comb begin
    ch_cnt_d = ch_cnt_q;
    phase_d  = phase_q;
    if (cfg_update) begin
      ch_cnt_d = '0;
      phase_d  = '0;
    end else if (beat_acc) begin
      if (ch_last) begin
        ch_cnt_d = '0;
        phase_d  = phase_last ? '0 : phase_q + FW'(1);
      end else begin
        ch_cnt_d = ch_cnt_q + CH_W'(1);
      end
    end
  end

  // Output register: reload on a producing beat, otherwise drain on handshake
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    if (produce) begin
      m_valid_d = 1'b1;
      m_data_d  = out_data;
      m_user_d  = ch_cnt_q;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // Configuration registers, latched with the factor already clamped
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      factor_q <= FW'(clamp_factor(DEFAULT_FACTOR, MAX_FACTOR));
      mode_q   <= MODE_PICK;
      shift_q  <= '0;
    end else if (cfg_update) begin
      factor_q <= FW'(clamp_factor(int'(cfg_factor), MAX_FACTOR));
      mode_q   <= cfg_mode;
      shift_q  <= cfg_shift;
    end
  end

  // State registers for counters and the output stage
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ch_cnt_q  <= '0;
      phase_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
    end else begin
      ch_cnt_q  <= ch_cnt_d;
      phase_q   <= phase_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_axis_decimator                                         |
// | Brief    : Self-checking bench for axis_decimator (2 channels) with  |
// |            a frame/phase arithmetic reference model and scoreboard.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_axis_decimator;

  localparam int N_CH  = 2;
  localparam int MAXF  = 16;
  localparam int DEFF  = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cfg_update = 1'b0;
  logic [4:0] cfg_factor = '0;
  logic       cfg_mode = 1'b0;
  logic [3:0] cfg_shift = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = '0;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic [7:0] m_axis_tdata;
  logic [0:0] m_axis_tuser;

  axis_decimator #(
    .TDATA_WIDTH    (8),
    .N_CHANNELS     (N_CH),
    .MAX_FACTOR     (MAXF),
    .DEFAULT_FACTOR (DEFF)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_update    (cfg_update),
    .cfg_factor    (cfg_factor),
    .cfg_mode      (cfg_mode),
    .cfg_shift     (cfg_shift),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: beat k after a restart belongs to channel k%N, frame k/N
  int mdl_f = DEFF, mdl_mode = 0, mdl_sh = 0, mdl_k = 0;
  int mdl_sum [N_CH];
  int exp_d[$], exp_u[$];
  int log_d[$], log_u[$];
  bit pend = 0, stall = 0;
  int pend_d = 0, pend_u = 0, prev_d = 0, prev_u = 0;
  bit rand_rdy = 0;

  function automatic int clampf(input int f);
    if (f == 0) return 1;
    if (f > MAXF) return MAXF;
    return f;
  endfunction

  task automatic model_restart();
    mdl_k = 0;
    for (int i = 0; i < N_CH; i++) mdl_sum[i] = 0;
  endtask

  task automatic model_beat(input int d);
    int ch, ph;
    ch = mdl_k % N_CH;
    ph = (mdl_k / N_CH) % mdl_f;
    if (mdl_mode == 0) begin
      if (ph == 0) begin
        exp_d.push_back(d); exp_u.push_back(ch);
        pend = 1; pend_d = d; pend_u = ch;
      end
    end else begin
      mdl_sum[ch] = (ph == 0) ? d : mdl_sum[ch] + d;
      if (ph == mdl_f - 1) begin
        pend_d = (mdl_sum[ch] >> mdl_sh) & 255;
        pend_u = ch;
        exp_d.push_back(pend_d); exp_u.push_back(pend_u);
        pend = 1;
      end
    end
    mdl_k++;
  endtask

  // Monitor on the falling edge: what it sees decides the next rising edge
  always @(negedge aclk) begin
    if (!aresetn) begin
      mdl_f = DEFF; mdl_mode = 0; mdl_sh = 0;
      model_restart();
      exp_d.delete(); exp_u.delete();
      pend = 0; stall = 0;
    end else begin
      check("s_tready_rule", s_axis_tready, (!m_axis_tvalid || m_axis_tready));
      if (stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, prev_d);
        check("stall_user", m_axis_tuser, prev_u);
      end
      if (pend) begin
        check("lat_valid", m_axis_tvalid, 1);
        check("lat_data", m_axis_tdata, pend_d);
        check("lat_user", m_axis_tuser, pend_u);
      end
      pend = 0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_d.size() == 0) begin
          check("out_extra", exp_d.size(), 1);
        end else begin
          check("out_data", m_axis_tdata, exp_d.pop_front());
          check("out_user", m_axis_tuser, exp_u.pop_front());
        end
        log_d.push_back(m_axis_tdata); log_u.push_back(m_axis_tuser);
      end
      stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata; prev_u = m_axis_tuser;
      if (cfg_update) begin
        mdl_f = clampf(cfg_factor); mdl_mode = cfg_mode; mdl_sh = cfg_shift;
        model_restart();
      end else if (s_axis_tvalid && s_axis_tready) begin
        model_beat(s_axis_tdata);
      end
    end
  end

  // Optional random back-pressure
  always @(posedge aclk) begin
    #1;
    if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
  end

  // All drive tasks start and end 1 time unit after a rising edge
  task automatic drive_beat(input int d);
    int n = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'(d);
    @(negedge aclk);
    while (!s_axis_tready && n < 200) begin n++; @(negedge aclk); end
    if (n >= 200) check("in_timeout", s_axis_tready, 1);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic apply_cfg(input int f, input int mode, input int sh, input bit with_beat, input int d);
    cfg_update = 1'b1; cfg_factor = 5'(f); cfg_mode = 1'(mode); cfg_shift = 4'(sh);
    s_axis_tvalid = with_beat; s_axis_tdata = 8'(d);
    @(posedge aclk); #1;
    cfg_update = 1'b0; s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 0; m_axis_tready = 1'b1; s_axis_tvalid = 1'b0;
    while ((exp_d.size() != 0 || m_axis_tvalid) && n < 100) begin @(posedge aclk); #1; n++; end
    check("drain", exp_d.size(), 0);
  endtask

  task automatic expect_log(input string tag, input int idx, input int d, input int u);
    if (idx >= log_d.size()) begin
      check(tag, log_d.size(), idx + 1);
    end else begin
      check(tag, log_d[idx], d);
      check(tag, log_u[idx], u);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid", m_axis_tvalid, 0);
    check("rst_data", m_axis_tdata, 0);
    check("rst_user", m_axis_tuser, 0);
    check("rst_ready", s_axis_tready, 1);
    #5 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Default factor 4, pick: beats 0..11 over two channels
    log_d.delete(); log_u.delete();
    for (int i = 0; i < 12; i++) drive_beat(i);
    drain();
    check("dflt_count", log_d.size(), 4);
    expect_log("dflt0", 0, 0, 0);
    expect_log("dflt1", 1, 1, 1);
    expect_log("dflt2", 2, 8, 0);
    expect_log("dflt3", 3, 9, 1);

    // Average F=2 shift=1
    log_d.delete(); log_u.delete();
    apply_cfg(2, 1, 1, 0, 0);
    drive_beat(10); drive_beat(100); drive_beat(20); drive_beat(200);
    drain();
    expect_log("avg0", 0, 15, 0);
    expect_log("avg1", 1, 150, 1);

    // Back-pressure with F=1
    log_d.delete(); log_u.delete();
    apply_cfg(1, 0, 0, 0, 0);
    m_axis_tready = 1'b0;
    drive_beat(50);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'd51;
    repeat (5) begin
      @(negedge aclk);
      check("bp_ready", s_axis_tready, 0);
      check("bp_data", m_axis_tdata, 50);
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    drive_beat(51); drive_beat(52);
    drain();
    check("bp_count", log_d.size(), 3);
    expect_log("bp0", 0, 50, 0);
    expect_log("bp1", 1, 51, 1);
    expect_log("bp2", 2, 52, 0);

    // Clamp: factor 0 passes everything
    log_d.delete(); log_u.delete();
    apply_cfg(0, 0, 0, 0, 0);
    drive_beat(3); drive_beat(4); drive_beat(5);
    drain();
    check("f0_count", log_d.size(), 3);
    expect_log("f0_2", 2, 5, 0);

    // Clamp: factor 31 -> 16, average of sixteen 255s per channel
    log_d.delete(); log_u.delete();
    apply_cfg(31, 1, 4, 0, 0);
    for (int i = 0; i < 32; i++) drive_beat(255);
    drain();
    check("f31_count", log_d.size(), 2);
    expect_log("f31_0", 0, 255, 0);
    expect_log("f31_1", 1, 255, 1);

    // cfg_update coincident with an accepted beat while an output is pending
    log_d.delete(); log_u.delete();
    apply_cfg(2, 0, 0, 0, 0);
    drive_beat(7);
    apply_cfg(2, 0, 0, 1, 99);
    drive_beat(5); drive_beat(6);
    drain();
    check("cfgmid_count", log_d.size(), 3);
    expect_log("cfgmid0", 0, 7, 0);
    expect_log("cfgmid1", 1, 5, 0);
    expect_log("cfgmid2", 2, 6, 1);

    // Asynchronous reset while an output is held
    apply_cfg(1, 0, 0, 0, 0);
    drive_beat(10); drive_beat(77);
    m_axis_tready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check("arst_valid", m_axis_tvalid, 0);
    check("arst_data", m_axis_tdata, 0);
    check("arst_user", m_axis_tuser, 0);
    #3 aresetn = 1'b1;
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    log_d.delete(); log_u.delete();
    for (int i = 0; i < 8; i++) drive_beat(i);
    drain();
    check("arst_count", log_d.size(), 2);
    expect_log("arst0", 0, 0, 0);
    expect_log("arst1", 1, 1, 1);

    // Randomised traffic across configurations
    for (int r = 0; r < 10; r++) begin
      int f, md, sh, nb;
      f  = $urandom_range(0, 31);
      md = $urandom_range(0, 1);
      sh = $urandom_range(0, 12);
      nb = $urandom_range(60, 160);
      apply_cfg(f, md, sh, 0, 0);
      rand_rdy = 1;
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 49) == 0) begin
          apply_cfg($urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 12), 1, $urandom_range(0, 255));
        end else if ($urandom_range(0, 3) == 0) begin
          @(posedge aclk); #1;
        end else begin
          drive_beat($urandom_range(0, 255));
        end
      end
      drain();
    end

    check("leftover", exp_d.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
